mux_stim_gen: RTL

- LFSR-driven stimulus and response-capture stage placed directly upstream of the 2x1 transmission-gate MUX (`mux_2x1`).
- Generates NUM_VEC pseudo-random (in_a, in_b, sel) vectors and holds each one stable for a settle window.
- Samples the MUX output at the end of each window, compares it against the expected value, and counts mismatches.
- Replaces free-running `$random` stimulus with a reproducible, seedable, clocked sequence.

---
 rtl/mux_stim_gen.sv | 97 +++++++++
 1 files changed

// File: rtl/mux_stim_gen.sv
// mux_stim_gen: seedable LFSR stimulus generator and response checker for a 2x1 MUX under test
module mux_stim_gen #(
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int                NUM_VEC    = 10,
    parameter int                SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_out,
    output logic       in_a,
    output logic       in_b,
    output logic       sel,
    output logic       busy,
    output logic       sample_vld,
    output logic       exp_out,
    output logic       mismatch,
    output logic [7:0] err_cnt,
    output logic       done
);
    localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(16'hB400);
    localparam logic [15:0]       LAST      = 16'(NUM_VEC);
    localparam logic [7:0]        SETTLE_LD = 8'(SETTLE_CYC - 1);
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, DONE} state_t;
    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nxt;
    logic [15:0]       vec_q, vec_d;
    logic [7:0]        settle_q, settle_d, err_q, err_d;
    logic [2:0]        abc_q, abc_d;
    logic              exp_q, exp_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED_EFF;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            abc_q    <= '0;
            exp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            abc_q    <= abc_d;
            exp_q    <= exp_d;
        end
    end
    always_comb begin
        lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        abc_d    = abc_q;
        exp_d    = exp_q;
        // case inequality so X/Z from a switch-level MUX counts as an error
        mismatch = (state_q == SAMPLE) && (mux_out !== exp_q);
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                err_d   = '0;
                vec_d   = '0;
            end
            LOAD: begin
                lfsr_d   = lfsr_nxt;
                abc_d    = lfsr_nxt[2:0];
                exp_d    = lfsr_nxt[2] ? lfsr_nxt[1] : lfsr_nxt[0];
                settle_d = SETTLE_LD;
                state_d  = (SETTLE_CYC > 0) ? SETTLE : SAMPLE;
            end
            SETTLE: begin
                settle_d = settle_q - 8'd1;
                state_d  = (settle_q == 8'd0) ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                err_d   = (mismatch && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
                vec_d   = vec_q + 16'd1;
                state_d = (vec_q + 16'd1 == LAST) ? DONE : LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign in_a       = abc_q[0];
    assign in_b       = abc_q[1];
    assign sel        = abc_q[2];
    assign exp_out    = exp_q;
    assign busy       = state_q != IDLE;
    assign sample_vld = state_q == SAMPLE;
    assign done       = state_q == DONE;
    assign err_cnt    = err_q;
endmodule
